// File: rtl/keypad_scanner.sv
// keypad_scanner
//  Scans a 4x4 active-low matrix keypad one column at a time and debounces
//  the result. It gives the game control FSM a held key code and a one-cycle
//  confirm strobe.
//  Positions 0..14 map to key codes 1..15. Position 15 (row3,col3) is the
//  CONFIRM key: it raises held and pulses c, but never shows up on key.
//
// Parameters
//  SCAN_DIV        clk cycles each column is driven (>=4, leaves room for
//                  the 2-flop row synchronizer to settle)
//  DEBOUNCE_SCANS  consecutive identical full scans needed to commit (1..15)
//
// Ports
//  clk    in   1  clock
//  rst    in   1  synchronous active-high reset
//  row_n  in   4  keypad rows, active-low, asynchronous to clk
//  col_n  out  4  column drive, active-low, one-hot low
//  key    out  4  debounced key code 1..15, 0 = none or CONFIRM
//  c      out  1  one-cycle pulse when a CONFIRM press is committed
//  held   out  1  high while any debounced key is held, CONFIRM included
module keypad_scanner #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key,
   output logic       c,
   output logic       held
);

   localparam int          DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   // Position codes are 0..15; 16 stands for "nothing pressed".
   localparam logic [4:0]  NONE     = 5'd16;
   localparam logic [4:0]  CONFIRM  = 5'd15;

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_q, col_d;
   logic [3:0]       row_s1_q, row_s1_d;
   logic [3:0]       row_s2_q, row_s2_d;
   logic [15:0]      press_q, press_d;
   logic [4:0]       cand_q, cand_d;
   logic [4:0]       stable_q, stable_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       key_q, key_d;
   logic             held_q, held_d;
   logic             c_q, c_d;

   logic             sample;
   logic             scan_end;
   logic [15:0]      scan_bits;
   logic [4:0]       raw;

   // All state registers; the rows are held at "released" during reset so
   // the first scan after reset never sees a phantom press.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= '0;
         col_q    <= '0;
         row_s1_q <= 4'hF;
         row_s2_q <= 4'hF;
         press_q  <= '0;
         cand_q   <= NONE;
         stable_q <= NONE;
         cnt_q    <= '0;
         key_q    <= '0;
         held_q   <= 1'b0;
         c_q      <= 1'b0;
      end else begin
         div_q    <= div_d;
         col_q    <= col_d;
         row_s1_q <= row_s1_d;
         row_s2_q <= row_s2_d;
         press_q  <= press_d;
         cand_q   <= cand_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         held_q   <= held_d;
         c_q      <= c_d;
      end
   end

   // Column timing, row sampling and the raw scan result. The rows are sampled
   // on the last cycle of each column window. The column-3 rows are merged
   // straight into scan_bits, so the scan-end edge sees the complete matrix.
   always_comb begin
      sample   = (div_q == DIV_LAST);
      scan_end = sample && (col_q == 2'd3);

      row_s1_d = row_n;
      row_s2_d = row_s1_q;

      if (sample) begin
         div_d = '0;
         col_d = col_q + 2'd1;
      end else begin
         div_d = div_q + DIV_W'(1);
         col_d = col_q;
      end

      scan_bits = press_q;
      if (sample) begin
         for (int r = 0; r < 4; r++) begin
            scan_bits[{2'(r), col_q}] = ~row_s2_q[r];
         end
      end

      if (scan_end) begin
         press_d = '0;
      end else begin
         press_d = scan_bits;
      end

      // The loop runs downward, so the lowest pressed index is written last and wins.
      raw = NONE;
      for (int i = 15; i >= 0; i--) begin
         if (scan_bits[i]) begin
            raw = 5'(i);
         end
      end
   end

   // Debounce and output update. A change needs DEBOUNCE_SCANS identical
   // scans in a row before it commits. The outputs are computed from the
   // committing value on the same edge, so key moves straight from one code
   // to another without passing through 0. c fires only on a commit into
   // CONFIRM. A commit needs cand != stable, so holding CONFIRM never repeats c.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      key_d    = key_q;
      held_d   = held_q;
      c_d      = 1'b0;

      if (scan_end) begin
         if (raw == cand_q) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
         end else begin
            cand_d = raw;
            cnt_d  = 4'd1;
         end

         if ((cnt_d >= 4'(DEBOUNCE_SCANS)) && (cand_d != stable_q)) begin
            stable_d = cand_d;
            key_d    = (cand_d < CONFIRM) ? (cand_d[3:0] + 4'd1) : 4'd0;
            held_d   = (cand_d != NONE);
            c_d      = (cand_d == CONFIRM);
         end
      end
   end

   assign col_n = ~(4'b0001 << col_q);
   assign key   = key_q;
   assign held  = held_q;
   assign c     = c_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//  Self-checking bench for keypad_scanner at the default parameters
//  (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 cycles).
//  A behavioural keypad matrix pulls a row low whenever a pressed key sits
//  in the column that is currently driven low. The table vectors push their
//  expectations into a scoreboard queue. Each entry is popped and compared
//  once its settle window has been observed.
module tb_keypad_scanner;

   logic       clk;
   logic       rst;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key;
   logic       c;
   logic       held;

   logic [15:0] pressed;

   int compared;
   int mismatched;

   typedef struct {
      logic [15:0] pressed;
      logic [3:0]  exp_key;
      logic        exp_held;
      int          exp_c;
      logic        no_zero;
   } vec_t;

   localparam int NUM_VECS = 13;
   localparam int SETTLE   = 96;

   vec_t vecs [NUM_VECS];
   vec_t sb_q [$];

   int c_cnt;
   int zero_cnt;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .row_n (row_n),
      .col_n (col_n),
      .key   (key),
      .c     (c),
      .held  (held)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Keypad matrix model with pull-ups on every row.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            if (pressed[r*4+k] && !col_n[k]) begin
               row_n[r] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Drive one table vector and record what it should produce.
   task automatic apply_stimulus(input int idx);
      pressed = vecs[idx].pressed;
      sb_q.push_back(vecs[idx]);
   endtask

   // Watch a settle window, then compare against the oldest scoreboard entry.
   task automatic check_output(input int idx);
      vec_t e;
      c_cnt    = 0;
      zero_cnt = 0;
      for (int i = 0; i < SETTLE; i++) begin
         @(negedge clk);
         if (c) c_cnt++;
         if (key == 4'd0) zero_cnt++;
      end
      if (sb_q.size() == 0) begin
         check($sformatf("vec%0d scoreboard empty", idx), 0, 1);
      end else begin
         e = sb_q.pop_front();
         check($sformatf("vec%0d key", idx), int'(key), int'(e.exp_key));
         check($sformatf("vec%0d held", idx), int'(held), int'(e.exp_held));
         check($sformatf("vec%0d c cycles", idx), c_cnt, e.exp_c);
         if (e.no_zero) begin
            check($sformatf("vec%0d key zero cycles", idx), zero_cnt, 0);
         end
      end
   endtask

   initial begin
      int first_c;
      int nz_cnt;
      int held_cnt;
      logic [3:0] exp_col;

      compared   = 0;
      mismatched = 0;
      pressed    = '0;
      rst        = 1'b1;

      vecs[0]  = '{16'h0000, 4'd0,  1'b0, 0, 1'b0};
      vecs[1]  = '{16'h0040, 4'd7,  1'b1, 0, 1'b0};
      vecs[2]  = '{16'h0000, 4'd0,  1'b0, 0, 1'b0};
      vecs[3]  = '{16'h8000, 4'd0,  1'b1, 1, 1'b0};
      vecs[4]  = '{16'h8000, 4'd0,  1'b1, 0, 1'b0};
      vecs[5]  = '{16'h0000, 4'd0,  1'b0, 0, 1'b0};
      vecs[6]  = '{16'h8000, 4'd0,  1'b1, 1, 1'b0};
      vecs[7]  = '{16'h0102, 4'd2,  1'b1, 0, 1'b0};
      vecs[8]  = '{16'h0100, 4'd9,  1'b1, 0, 1'b1};
      vecs[9]  = '{16'h0001, 4'd1,  1'b1, 0, 1'b1};
      vecs[10] = '{16'h4000, 4'd15, 1'b1, 0, 1'b1};
      vecs[11] = '{16'h8008, 4'd4,  1'b1, 0, 1'b0};
      vecs[12] = '{16'h0000, 4'd0,  1'b0, 0, 1'b0};

      // Reset values, then the column walk.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset col_n", int'(col_n), 4'b1110);
      check("reset key", int'(key), 0);
      check("reset c", int'(c), 0);
      check("reset held", int'(held), 0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_col = ~(4'b0001 << k);
         check($sformatf("col_n step %0d", k), int'(col_n), int'(exp_col));
         repeat (4) @(negedge clk);
      end
      check("col_n wrap", int'(col_n), 4'b1110);

      // Table-driven press/release patterns.
      for (int v = 0; v < NUM_VECS; v++) begin
         apply_stimulus(v);
         check_output(v);
      end

      // Bouncy contact: the toggling is faster than three matching scans.
      nz_cnt   = 0;
      held_cnt = 0;
      c_cnt    = 0;
      for (int i = 0; i < 300; i++) begin
         if ((i % 20) == 0) pressed[0] = ~pressed[0];
         @(negedge clk);
         if (key != 4'd0) nz_cnt++;
         if (held) held_cnt++;
         if (c) c_cnt++;
      end
      check("bounce key nonzero cycles", nz_cnt, 0);
      check("bounce held cycles", held_cnt, 0);
      check("bounce c cycles", c_cnt, 0);
      pressed = '0;
      repeat (SETTLE) @(negedge clk);

      // Reset partway through a CONFIRM debounce.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      pressed = 16'h8000;
      rst     = 1'b0;
      c_cnt   = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (c) c_cnt++;
      end
      check("partial debounce c cycles", c_cnt, 0);
      check("partial debounce held", int'(held), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("mid reset c", int'(c), 0);
      check("mid reset held", int'(held), 0);
      check("mid reset key", int'(key), 0);
      check("mid reset col_n", int'(col_n), 4'b1110);
      rst     = 1'b0;
      c_cnt   = 0;
      first_c = -1;
      for (int i = 1; i <= 70; i++) begin
         @(negedge clk);
         if (c) begin
            c_cnt++;
            if (first_c < 0) first_c = i;
         end
      end
      check("post reset c cycles", c_cnt, 1);
      check("post reset c latency", first_c, 48);
      check("post reset held", int'(held), 1);
      check("post reset key", int'(key), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
